// File: rtl/clock_display_pkg.sv
// Shared constants for the time-of-day display path: 7-segment encodings,
// digit positions, legal time limits and the converter state type.
package clock_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_HT = 2'd3;
    localparam logic [1:0] DIG_HO = 2'd2;
    localparam logic [1:0] DIG_MT = 2'd1;
    localparam logic [1:0] DIG_MO = 2'd0;

    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MINUTE_MAX = 6'd59;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_splitter.sv
// Sequential two-operand binary-to-BCD splitter: repeated parallel subtract-10.
//   state     | meaning
//   CONV_IDLE | waiting for start, ready=1
//   CONV_RUN  | subtracting 10 from each remainder still >= 10
module bcd_splitter
    import clock_display_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         ready,
    output logic         done,
    output logic [3:0]   a_tens,
    output logic [3:0]   a_ones,
    output logic [3:0]   b_tens,
    output logic [3:0]   b_ones
);

    localparam logic [W-1:0] TEN = W'(10);

    conv_state_t  state;
    logic [W-1:0] a_rem;
    logic [W-1:0] b_rem;
    logic         a_big;
    logic         b_big;

    assign a_big  = (a_rem >= TEN);
    assign b_big  = (b_rem >= TEN);
    assign ready  = (state == CONV_IDLE);
    // done is combinational so the caller captures digits on the edge that ends the run
    assign done   = (state == CONV_RUN) && !a_big && !b_big;
    assign a_ones = a_rem[3:0];
    assign b_ones = b_rem[3:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= CONV_IDLE;
            a_rem  <= '0;
            b_rem  <= '0;
            a_tens <= 4'd0;
            b_tens <= 4'd0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        a_rem  <= a_in;
                        b_rem  <= b_in;
                        a_tens <= 4'd0;
                        b_tens <= 4'd0;
                        state  <= CONV_RUN;
                    end
                end
                CONV_RUN: begin
                    if (a_big) begin
                        a_rem  <= a_rem - TEN;
                        a_tens <= a_tens + 4'd1;
                    end
                    if (b_big) begin
                        b_rem  <= b_rem - TEN;
                        b_tens <= b_tens + 4'd1;
                    end
                    if (!a_big && !b_big) state <= CONV_IDLE;
                end
                default: state <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/time_display_scan.sv
// HH:MM multiplexed 7-segment driver: load/range check, BCD conversion,
// digit scan, leading-zero blanking and a second-rate colon.
module time_display_scan
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV_W    = 10,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic       load,
    input  logic       second_tick,
    input  logic       blank,
    output logic       ready,
    output logic       range_err,
    output logic [6:0] segment,
    output logic       dp,
    output logic [3:0] digit_en
);

    logic                  conv_done;
    logic [3:0]            h_tens, h_ones, m_tens, m_ones;
    logic                  in_range;
    logic                  load_ok;
    logic [SCAN_DIV_W-1:0] prescale;
    logic [1:0]            dig_idx;
    logic                  colon;
    logic [3:0][3:0]       disp_buf;
    logic [1:0]            idx_next;
    logic [3:0][3:0]       buf_next;
    logic                  colon_next;
    logic [3:0]            digit_val;
    logic [6:0]            seg_next;
    logic                  dp_next;

    assign in_range = (hour <= HOUR_MAX) && (minute <= MINUTE_MAX);
    assign load_ok  = load && ready && in_range;

    bcd_splitter #(.W(6)) u_bcd (
        .clock  (clock),
        .reset  (reset),
        .start  (load_ok),
        .a_in   ({1'b0, hour}),
        .b_in   (minute),
        .ready  (ready),
        .done   (conv_done),
        .a_tens (h_tens),
        .a_ones (h_ones),
        .b_tens (m_tens),
        .b_ones (m_ones)
    );

    // Outputs are built from next-state values so all three registers move together
    always_comb begin
        idx_next = dig_idx;
        if (&prescale) idx_next = dig_idx - 2'd1;
        buf_next = disp_buf;
        if (conv_done) buf_next = {h_tens, h_ones, m_tens, m_ones};
        colon_next = colon ^ second_tick;
        digit_val  = buf_next[idx_next];
        seg_next   = seg_encode(digit_val);
        if (BLANK_LEADING && (idx_next == DIG_HT) && (digit_val == 4'd0)) seg_next = SEG_BLANK;
        if (blank) seg_next = SEG_BLANK;
        dp_next = !blank && colon_next && (idx_next == DIG_HO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale  <= '0;
            dig_idx   <= DIG_HT;
            colon     <= 1'b0;
            disp_buf  <= '0;
            segment   <= SEG_BLANK;
            dp        <= 1'b0;
            digit_en  <= 4'b1000;
            range_err <= 1'b0;
        end else begin
            prescale  <= prescale + SCAN_DIV_W'(1);
            dig_idx   <= idx_next;
            colon     <= colon_next;
            disp_buf  <= buf_next;
            segment   <= seg_next;
            dp        <= dp_next;
            digit_en  <= 4'b0001 << idx_next;
            range_err <= load && ready && !in_range;
        end
    end

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench for time_display_scan with SCAN_DIV_W=2: per-cycle
// comparison against a cycle-count reference model plus literal frame checks.
module tb_time_display_scan;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] hour = '0;
    logic [5:0] minute = '0;
    logic       load = 1'b0;
    logic       second_tick = 1'b0;
    logic       blank = 1'b0;
    logic       ready;
    logic       range_err;
    logic [6:0] segment;
    logic       dp;
    logic [3:0] digit_en;

    int checks = 0;
    int failures = 0;

    time_display_scan #(.SCAN_DIV_W(2), .BLANK_LEADING(1'b1)) dut (
        .clock       (clock),
        .reset       (reset),
        .hour        (hour),
        .minute      (minute),
        .load        (load),
        .second_tick (second_tick),
        .blank       (blank),
        .ready       (ready),
        .range_err   (range_err),
        .segment     (segment),
        .dp          (dp),
        .digit_en    (digit_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the frame follows from edges since reset,
    // conversion is a countdown of max(tens)+1 edges.
    logic [6:0] enc [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    bit   model_valid = 0;
    int   k = 0;
    int   busy_left = 0;
    int   m_buf [4];
    int   pend [4];
    bit   m_colon = 0;
    bit   m_err = 0;
    int   exp_seg, exp_dp, exp_en, exp_ready;

    always @(posedge clock) begin
        bit was_idle, ok;
        int h, m, idx, d;
        h = int'(hour);
        m = int'(minute);
        if (reset) begin
            k = 0; busy_left = 0; m_colon = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_buf[i] = 0;
            model_valid = 1;
        end else begin
            was_idle = (busy_left == 0);
            ok = (h < 24) && (m < 60);
            m_err = load && was_idle && !ok;
            m_colon = m_colon ^ second_tick;
            if (!was_idle) begin
                busy_left--;
                if (busy_left == 0) m_buf = pend;
            end else if (load && ok) begin
                busy_left = ((h / 10 > m / 10) ? h / 10 : m / 10) + 1;
                pend[3] = h / 10; pend[2] = h % 10;
                pend[1] = m / 10; pend[0] = m % 10;
            end
            k++;
        end
        idx = 3 - ((k / 4) % 4);
        d = m_buf[idx];
        exp_en = 1 << idx;
        exp_seg = (reset || blank || (idx == 3 && d == 0)) ? 0 : int'(enc[d]);
        exp_dp = (!reset && !blank && m_colon && idx == 2) ? 1 : 0;
        exp_ready = (busy_left == 0) ? 1 : 0;
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("segment", int'(segment), exp_seg);
            check("dp", int'(dp), exp_dp);
            check("digit_en", int'(digit_en), exp_en);
            check("ready", int'(ready), exp_ready);
            check("range_err", int'(range_err), int'(m_err));
        end
    end

    task automatic wait_en(input logic [3:0] en);
        int n = 0;
        while (digit_en != en && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (digit_en != en) check("digit_en_timeout", int'(digit_en), int'(en));
    endtask

    task automatic check_frame(input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
        wait_en(4'b1000); check("frame_d3", int'(segment), int'(e3));
        wait_en(4'b0100); check("frame_d2", int'(segment), int'(e2));
        wait_en(4'b0010); check("frame_d1", int'(segment), int'(e1));
        wait_en(4'b0001); check("frame_d0", int'(segment), int'(e0));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_load(input int h, input int m);
        @(negedge clock);
        hour = 5'(h); minute = 6'(m); load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [3:0] en0;

        repeat (3) @(negedge clock);
        check("rst_segment", int'(segment), 0);
        check("rst_dp", int'(dp), 0);
        check("rst_digit_en", int'(digit_en), 4'b1000);
        check("rst_ready", int'(ready), 1);
        check("rst_range_err", int'(range_err), 0);
        reset = 1'b0;

        // 13:45 -> four busy edges of subtraction plus the write edge
        do_load(13, 45);
        cnt = 0;
        while (!ready && cnt < 20) begin
            cnt++;
            @(negedge clock);
        end
        check("busy_cycles_13_45", cnt, 5);
        check_frame(7'h06, 7'h4F, 7'h66, 7'h6D);

        // out-of-range loads
        @(negedge clock);
        hour = 5'd24; minute = 6'd10; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        check("err_hour_pulse", int'(range_err), 1);
        check("err_hour_ready", int'(ready), 1);
        @(negedge clock);
        check("err_hour_clear", int'(range_err), 0);
        hour = 5'd5; minute = 6'd60; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        check("err_min_pulse", int'(range_err), 1);
        @(negedge clock);
        check("err_min_clear", int'(range_err), 0);
        check_frame(7'h06, 7'h4F, 7'h66, 7'h6D);

        // leading zero blanking
        do_load(5, 7);
        wait_ready();
        check_frame(7'h00, 7'h6D, 7'h3F, 7'h07);
        do_load(0, 0);
        wait_ready();
        check_frame(7'h00, 7'h3F, 7'h3F, 7'h3F);

        // colon toggle plus a load issued while busy
        do_load(12, 34);
        second_tick = 1'b1; hour = 5'd9; minute = 6'd59; load = 1'b1;
        @(negedge clock);
        second_tick = 1'b0; load = 1'b0;
        wait_ready();
        check_frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        wait_en(4'b0100);
        check("dp_colon_on", int'(dp), 1);
        second_tick = 1'b1;
        @(negedge clock);
        second_tick = 1'b0;
        wait_en(4'b1000);
        wait_en(4'b0100);
        check("dp_colon_off", int'(dp), 0);

        // blank mid-frame
        wait_en(4'b0010);
        blank = 1'b1;
        @(negedge clock);
        check("blank_segment", int'(segment), 0);
        check("blank_dp", int'(dp), 0);
        en0 = digit_en;
        repeat (4) @(negedge clock);
        check("blank_rotates", int'(digit_en != en0), 1);
        blank = 1'b0;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            load = ($urandom_range(5) == 0);
            hour = 5'($urandom_range(31));
            minute = 6'($urandom_range(63));
            second_tick = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) blank = ~blank;
        end
        @(negedge clock);
        load = 1'b0; second_tick = 1'b0; blank = 1'b0;
        wait_ready();

        // reset mid-conversion
        do_load(23, 59);
        @(negedge clock);
        check("busy_before_reset", int'(ready), 0);
        reset = 1'b1;
        @(negedge clock);
        check("reset_abort_ready", int'(ready), 1);
        reset = 1'b0;
        check_frame(7'h00, 7'h3F, 7'h3F, 7'h3F);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_display_scan.md
# time_display_scan

Downstream display stage of the time-of-day clock. It consumes the binary hour/minute count from the clock counters and converts it sequentially to BCD. It then drives a 4-digit multiplexed 7-segment display (HH:MM) with leading-zero blanking and a second-rate colon. It replaces the fixed-pattern digit driver at the top level.

## Interface
Parameters:
- SCAN_DIV_W, default 10: prescaler width; each digit is shown for 2^SCAN_DIV_W cycles.
- BLANK_LEADING, default 1: when 1, hour tens digit value 0 is shown blank.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- hour  in  5  binary hour, legal 0..23.
- minute  in  6  binary minute, legal 0..59.
- load  in  1  one-cycle strobe that captures hour/minute.
- second_tick  in  1  one-cycle pulse per second; toggles the colon.
- blank  in  1  forces segment and dp to 0 while high.
- ready  out  1  high when the converter is idle.
- range_err  out  1  one-cycle pulse when a load is rejected.
- segment  out  7  active-high segments; bit0=a … bit6=g.
- dp  out  1  colon / decimal point, active-high.
- digit_en  out  4  one-hot digit select; bit3=hour tens, bit0=minute ones.

## Operation
- Reset values:
  - ready=1, range_err=0, segment=0, dp=0, digit_en=4'b1000.
  - Display buffer = 0,0,0,0.
  - Prescaler=0, digit index=3, colon state=0.
- Load acceptance:
  - load while ready=1 with hour<24 and minute<60: capture both into working registers; ready drops next edge.
  - load while ready=1 with hour≥24 or minute≥60: ignored; range_err=1 for exactly one cycle; buffer unchanged.
  - load while ready=0: ignored silently (no range check, no err).
- Converter: FSM IDLE → CONV → IDLE.
  - In CONV, each cycle subtracts 10 in parallel from each working register that is ≥10, and increments its tens count.
  - When both remainders are <10, the tens/ones digits for hour and minute are written to the display buffer. On that same edge the FSM returns to IDLE (ready=1).
- Scan:
  - Prescaler increments every cycle regardless of state or blank.
  - On the cycle where the prescaler is all ones, the digit index advances 3→2→1→0→3.
- Decode encodings: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
- Segment output:
  - Index 3 with hour tens=0 and BLANK_LEADING=1 → 7'h00.
  - Otherwise the encoded buffer digit for the index.
- Colon: colon state toggles on every second_tick. dp = colon state AND index==2.
- blank=1: segment=0 and dp=0; digit_en keeps rotating.
- Simultaneous events:
  - second_tick and load in the same cycle are both honoured.
  - A buffer update landing on a digit-advance edge: the new digit uses the new buffer value.

## Timing
- segment, dp and digit_en are registered and change on the same edge with no skew. All three are derived from the next index/buffer/blank/colon values.
- Conversion latency: ready returns high N+1 edges after the load edge, where N = max(hour/10, minute/10). Worst case is 6 cycles (minute 50..59).
- Digit dwell is 2^SCAN_DIV_W cycles; a full frame is 4·2^SCAN_DIV_W cycles.
- The first index advance after reset occurs on edge 2^SCAN_DIV_W.
- blank takes effect on the edge after it is sampled.
- Reset asserted mid-conversion aborts the conversion and restores all reset values on the next edge.

## Structure
- Package clock_display_pkg holds:
  - 7-segment encoding constants for digits 0..9 and blank.
  - Digit index localparams (DIG_HT=3, DIG_HO=2, DIG_MT=1, DIG_MO=0).
  - Limits HOUR_MAX=23 and MINUTE_MAX=59.
- One sub-module, bcd_splitter: the sequential subtract-10 converter with start/done, instantiated once with width 6. The hour value is zero-extended.
- The top level holds the prescaler, digit index, display buffer, colon state and output registers.

## Test plan
All scenarios use SCAN_DIV_W=2.
- Reset held for 3 cycles → segment=00, dp=0, digit_en=1000, ready=1, range_err=0.
- load hour=13, minute=45 → ready low for 5 cycles. Next frame shows digit3 06, digit2 4F, digit1 66, digit0 6D.
- load hour=24, minute=10, then hour=5, minute=60 → two single-cycle range_err pulses; ready stays 1; display unchanged.
- BLANK_LEADING=1:
  - load 5:07 → digit3 00, digit2 6D, digit1 3F, digit0 07.
  - load 0:00 → digit3 00, digit2 3F.
- Two second_tick pulses plus a second load issued while ready=0:
  - dp is 1 only during digit2 between the pulses.
  - The second load is ignored.
- blank raised mid-frame → segment=00 and dp=0 from the next edge while digit_en keeps rotating. Reset during conversion → ready=1 and buffer back to zeros.
